// File: rtl/freq_div_prog_if.sv
// Control and status bundle for the programmable clock divider.
// The master side owns enable and divisor loading; the slave side is the divider.
interface freq_div_prog_if #(
  parameter int WIDTH = 16
);
  logic             en;
  logic [WIDTH-1:0] div_val;
  logic             div_load;
  logic             out_clk;
  logic             tick;
  logic [WIDTH-1:0] div_act;
  logic             upd_pend;
  logic             div_err;

  modport master (
    output en, div_val, div_load,
    input  out_clk, tick, div_act, upd_pend, div_err
  );

  modport slave (
    input  en, div_val, div_load,
    output out_clk, tick, div_act, upd_pend, div_err
  );
endinterface

// File: rtl/freq_div_prog.sv
// Runtime-programmable integer clock divider.
// Odd divisors reach 50% duty by OR-ing the period flop with a negedge copy of itself.
// A newly loaded divisor only takes effect at a period wrap (or while stopped),
// so out_clk never produces a runt pulse.
//
// state   | meaning
// ST_IDLE | stopped; counter cleared, out_clk low, pending divisor applied each cycle
// ST_RUN  | counting 0..div_act-1; out_clk high for the first half of the period
module freq_div_prog #(
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 4
) (
  input logic            orgin_clk,
  input logic            reset_n,
  freq_div_prog_if.slave bus
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  localparam logic [WIDTH-1:0] LP_DEF = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] LP_ONE = WIDTH'(1);
  localparam logic [WIDTH-1:0] LP_TWO = WIDTH'(2);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] w_cnt_step;
  logic [WIDTH-1:0] w_half;
  logic             r_pos;
  logic             w_pos_nxt;
  logic             r_neg;
  logic             r_tick;
  logic             w_tick_nxt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] r_div_pend;
  logic [WIDTH-1:0] w_div_req;
  logic             r_upd_pend;
  logic             r_div_err;
  logic             w_wrap;
  logic             w_apply;
  logic             w_bad_val;

  // H is derived from the divisor in effect; it only changes at a wrap.
  assign w_half     = r_div_act >> 1;
  assign w_wrap     = (r_cnt == (r_div_act - LP_ONE));
  assign w_cnt_step = w_wrap ? '0 : (r_cnt + LP_ONE);
  // While stopped the counter sits at 0, so applying there is also runt-free.
  assign w_apply    = (r_state == ST_IDLE) || w_wrap;
  assign w_bad_val  = (bus.div_val < LP_TWO);
  assign w_div_req  = w_bad_val ? LP_TWO : bus.div_val;

  // Next-state and next-counter decode for the run/stop sequencer.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_pos_nxt   = r_pos;
    w_tick_nxt  = 1'b0;
    if (!bus.en) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_pos_nxt   = 1'b0;
    end else if (r_state == ST_IDLE) begin
      w_state_nxt = ST_RUN;
      w_cnt_nxt   = '0;
      w_pos_nxt   = 1'b1;
      w_tick_nxt  = 1'b1;
    end else begin
      w_cnt_nxt   = w_cnt_step;
      w_pos_nxt   = (w_cnt_step < w_half);
      w_tick_nxt  = (w_cnt_step == '0);
    end
  end

  // State, period counter, high-phase flop and tick registers.
  always_ff @(posedge orgin_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_pos   <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_pos   <= w_pos_nxt;
      r_tick  <= w_tick_nxt;
    end
  end

  // Divisor load/apply; a load in the apply cycle stays pending (load wins).
  always_ff @(posedge orgin_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_div_act  <= LP_DEF;
      r_div_pend <= LP_DEF;
      r_upd_pend <= 1'b0;
      r_div_err  <= 1'b0;
    end else begin
      r_div_err <= bus.div_load && w_bad_val;
      if (w_apply) begin
        r_div_act  <= r_div_pend;
        r_upd_pend <= 1'b0;
      end
      if (bus.div_load) begin
        r_div_pend <= w_div_req;
        r_upd_pend <= 1'b1;
      end
    end
  end

  // Half-cycle delayed copy of the high-phase flop, used to stretch odd periods.
  always_ff @(negedge orgin_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_neg <= 1'b0;
    end else begin
      r_neg <= r_pos;
    end
  end

  assign bus.out_clk  = r_div_act[0] ? (r_pos | r_neg) : r_pos;
  assign bus.tick     = r_tick;
  assign bus.div_act  = r_div_act;
  assign bus.upd_pend = r_upd_pend;
  assign bus.div_err  = r_div_err;

endmodule

// File: tb/tb_freq_div_prog.sv
// Bench for the programmable divider: table of divisor loads, directed corner
// sequences, and randomized enable/load traffic checked against a period/phase model.
module tb_freq_div_prog;
  localparam int WIDTH = 16;
  localparam int DEF   = 4;

  logic orgin_clk = 1'b0;
  logic reset_n   = 1'b1;

  freq_div_prog_if #(.WIDTH(WIDTH)) bus_if ();

  freq_div_prog #(.WIDTH(WIDTH), .DEFAULT_DIV(DEF)) dut (
    .orgin_clk (orgin_clk),
    .reset_n   (reset_n),
    .bus       (bus_if.slave)
  );

  always #5 orgin_clk = ~orgin_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position in the current period, divisor in effect, pending divisor.
  // out_clk is high during the first N half-cycles of each 2N half-cycle period.
  bit m_run  = 0;
  int m_p    = 0;
  int m_n    = DEF;
  int m_pend = DEF;
  bit m_upd  = 0;
  bit m_err  = 0;
  bit m_tick = 0;
  bit m_hi2  = 0;
  bit mdl_prev_hi2;
  bit mdl_end;
  int mdl_n_old;

  initial forever begin
    @(posedge orgin_clk or negedge reset_n);
    if (!reset_n) begin
      m_run = 0; m_p = 0; m_n = DEF; m_pend = DEF;
      m_upd = 0; m_err = 0; m_tick = 0; m_hi2 = 0;
    end else begin
      mdl_prev_hi2 = m_run && (2 * m_p + 1 < m_n);
      mdl_end      = !m_run || (m_p == m_n - 1);
      mdl_n_old    = m_n;
      m_err        = bus_if.div_load && (int'(bus_if.div_val) < 2);
      if (mdl_end) begin
        m_n   = m_pend;
        m_upd = 0;
      end
      if (bus_if.div_load) begin
        m_pend = (int'(bus_if.div_val) < 2) ? 2 : int'(bus_if.div_val);
        m_upd  = 1;
      end
      if (!bus_if.en) begin
        m_run = 0; m_p = 0; m_tick = 0;
      end else if (!m_run) begin
        m_run = 1; m_p = 0; m_tick = 1;
      end else begin
        m_p    = (m_p + 1) % mdl_n_old;
        m_tick = (m_p == 0);
      end
      m_hi2 = mdl_prev_hi2;
    end
  end

  // First half of each cycle: all outputs against the model.
  initial forever begin
    @(posedge orgin_clk);
    #1;
    chk("mdl_out_first_half", int'(bus_if.out_clk),
        int'(m_run ? (2 * m_p < m_n) : ((m_n % 2 == 1) && m_hi2)));
    chk("mdl_tick", int'(bus_if.tick), int'(m_tick));
    chk("mdl_div_act", int'(bus_if.div_act), m_n);
    chk("mdl_upd_pend", int'(bus_if.upd_pend), int'(m_upd));
    chk("mdl_div_err", int'(bus_if.div_err), int'(m_err));
  end

  // Second half of each cycle: out_clk only.
  initial forever begin
    @(negedge orgin_clk);
    #1;
    chk("mdl_out_second_half", int'(bus_if.out_clk), int'(m_run && (2 * m_p + 1 < m_n)));
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Advance to just after the next falling edge (inputs are driven there).
  task automatic step(input int n);
    repeat (n) begin
      @(negedge orgin_clk);
      #2;
    end
  endtask

  task automatic load_pulse(input int val);
    bus_if.div_load = 1'b1;
    bus_if.div_val  = WIDTH'(val);
    step(1);
    bus_if.div_load = 1'b0;
  endtask

  task automatic wait_upd_clear();
    int g = 0;
    while (bus_if.upd_pend && g < 64) begin
      step(1);
      g++;
    end
    chk("upd_clear", int'(bus_if.upd_pend), 0);
  endtask

  task automatic wait_tick();
    int g = 0;
    do begin
      @(posedge orgin_clk);
      #1;
      g++;
    end while (!bus_if.tick && g < 64);
    chk("tick_seen", int'(bus_if.tick), 1);
  endtask

  // Measures one full period between ticks and its high time in half-cycles.
  task automatic measure(output int per, output int hi);
    per = 0;
    hi  = 0;
    wait_tick();
    hi += int'(bus_if.out_clk);
    @(negedge orgin_clk); #1;
    hi += int'(bus_if.out_clk);
    per = 1;
    forever begin
      @(posedge orgin_clk); #1;
      if (bus_if.tick || per >= 64) break;
      hi += int'(bus_if.out_clk);
      @(negedge orgin_clk); #1;
      hi += int'(bus_if.out_clk);
      per++;
    end
    @(negedge orgin_clk); #2;
  endtask

  typedef struct {
    int val;
    int err;
    int act;
    int per;
    int hi;
  } vec_t;

  vec_t vecs[9];
  int   per, hi, g;
  bit   saw6;

  initial begin
    vecs[0] = '{val: 4,  err: 0, act: 4,  per: 4,  hi: 4};
    vecs[1] = '{val: 5,  err: 0, act: 5,  per: 5,  hi: 5};
    vecs[2] = '{val: 0,  err: 1, act: 2,  per: 2,  hi: 2};
    vecs[3] = '{val: 1,  err: 1, act: 2,  per: 2,  hi: 2};
    vecs[4] = '{val: 3,  err: 0, act: 3,  per: 3,  hi: 3};
    vecs[5] = '{val: 8,  err: 0, act: 8,  per: 8,  hi: 8};
    vecs[6] = '{val: 2,  err: 0, act: 2,  per: 2,  hi: 2};
    vecs[7] = '{val: 7,  err: 0, act: 7,  per: 7,  hi: 7};
    vecs[8] = '{val: 10, err: 0, act: 10, per: 10, hi: 10};

    bus_if.en       = 1'b0;
    bus_if.div_val  = '0;
    bus_if.div_load = 1'b0;
    #1 reset_n = 1'b0;
    step(3);
    reset_n = 1'b1;

    // Reset state and start latency
    chk("rst_out_clk", int'(bus_if.out_clk), 0);
    chk("rst_tick", int'(bus_if.tick), 0);
    chk("rst_div_act", int'(bus_if.div_act), DEF);
    chk("rst_upd_pend", int'(bus_if.upd_pend), 0);
    chk("rst_div_err", int'(bus_if.div_err), 0);
    step(1);
    chk("idle_out_clk", int'(bus_if.out_clk), 0);
    bus_if.en = 1'b1;
    @(posedge orgin_clk); #1;
    chk("first_rise_out", int'(bus_if.out_clk), 1);
    chk("first_rise_tick", int'(bus_if.tick), 1);
    @(negedge orgin_clk); #2;
    measure(per, hi);
    chk("default_period", per, 4);
    chk("default_high", hi, 4);

    // Table of divisor loads
    for (int i = 0; i < 9; i++) begin
      load_pulse(vecs[i].val);
      chk("vec_div_err", int'(bus_if.div_err), vecs[i].err);
      chk("vec_upd_set", int'(bus_if.upd_pend), 1);
      wait_upd_clear();
      chk("vec_div_act", int'(bus_if.div_act), vecs[i].act);
      measure(per, hi);
      chk("vec_period", per, vecs[i].per);
      chk("vec_high_halves", hi, vecs[i].hi);
    end

    // Back-to-back loads of 0 and 1: two error pulses
    load_pulse(0);
    chk("err_pulse_1", int'(bus_if.div_err), 1);
    load_pulse(1);
    chk("err_pulse_2", int'(bus_if.div_err), 1);
    step(1);
    chk("err_cleared", int'(bus_if.div_err), 0);
    wait_upd_clear();
    chk("err_div_act", int'(bus_if.div_act), 2);
    load_pulse(10);
    wait_upd_clear();

    // Two loads within one N=10 period: only the last is applied
    wait_tick();
    @(negedge orgin_clk); #2;
    load_pulse(6);
    step(2);
    load_pulse(3);
    saw6 = 0;
    g    = 0;
    while (bus_if.upd_pend && g < 30) begin
      if (bus_if.div_act == WIDTH'(6)) saw6 = 1;
      step(1);
      g++;
    end
    chk("last_load_wins_never6", int'(saw6), 0);
    chk("last_load_wins_act", int'(bus_if.div_act), 3);
    measure(per, hi);
    chk("last_load_period", per, 3);

    // Load 8 at cnt=1 with N=4: current period stays 4
    load_pulse(4);
    wait_upd_clear();
    wait_tick();
    @(posedge orgin_clk); #1;
    bus_if.div_load = 1'b1;
    bus_if.div_val  = WIDTH'(8);
    @(posedge orgin_clk); #1;
    bus_if.div_load = 1'b0;
    chk("mid_load_upd", int'(bus_if.upd_pend), 1);
    chk("mid_load_act", int'(bus_if.div_act), 4);
    @(posedge orgin_clk); #1;
    chk("mid_load_upd_hold", int'(bus_if.upd_pend), 1);
    chk("mid_load_act_hold", int'(bus_if.div_act), 4);
    @(posedge orgin_clk); #1;
    chk("wrap_apply_act", int'(bus_if.div_act), 8);
    chk("wrap_apply_upd", int'(bus_if.upd_pend), 0);
    chk("wrap_apply_tick", int'(bus_if.tick), 1);
    @(negedge orgin_clk); #2;
    measure(per, hi);
    chk("after_wrap_period", per, 8);
    chk("after_wrap_high", hi, 8);

    // Drop en at cnt=1 with N=7, then restart
    load_pulse(7);
    wait_upd_clear();
    wait_tick();
    @(posedge orgin_clk); #1;
    bus_if.en = 1'b0;
    @(posedge orgin_clk); #1;
    chk("stop_odd_hold", int'(bus_if.out_clk), 1);
    chk("stop_tick", int'(bus_if.tick), 0);
    @(negedge orgin_clk); #1;
    chk("stop_low", int'(bus_if.out_clk), 0);
    #1;
    step(2);
    chk("stopped_low", int'(bus_if.out_clk), 0);
    bus_if.en = 1'b1;
    @(posedge orgin_clk); #1;
    chk("restart_tick", int'(bus_if.tick), 1);
    chk("restart_out", int'(bus_if.out_clk), 1);
    @(negedge orgin_clk); #2;
    measure(per, hi);
    chk("restart_period", per, 7);
    chk("restart_high", hi, 7);

    // Async reset mid-period with N=9 and a load pending
    load_pulse(9);
    wait_upd_clear();
    wait_tick();
    @(negedge orgin_clk); #2;
    step(1);
    chk("pre_rst_out", int'(bus_if.out_clk), 1);
    load_pulse(5);
    chk("pre_rst_upd", int'(bus_if.upd_pend), 1);
    reset_n = 1'b0;
    #1;
    chk("async_rst_out", int'(bus_if.out_clk), 0);
    chk("async_rst_act", int'(bus_if.div_act), DEF);
    chk("async_rst_upd", int'(bus_if.upd_pend), 0);
    step(2);
    reset_n = 1'b1;
    @(posedge orgin_clk); #1;
    chk("post_rst_act", int'(bus_if.div_act), DEF);
    chk("post_rst_tick", int'(bus_if.tick), 1);
    @(negedge orgin_clk); #2;
    measure(per, hi);
    chk("post_rst_period", per, DEF);

    // Randomized enable/load traffic against the model
    for (int i = 0; i < 600; i++) begin
      bus_if.en       = ($urandom_range(0, 9) != 0);
      bus_if.div_load = ($urandom_range(0, 7) == 0);
      bus_if.div_val  = WIDTH'($urandom_range(0, 12));
      step(1);
    end
    bus_if.div_load = 1'b0;
    bus_if.en       = 1'b0;
    step(3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
